// File: rtl/display_bcd_controller.sv
// display_bcd_controller
//   Sequential front end for the 4-digit seven-segment path. A value written by
//   the output instruction is range-checked. In-range values are converted to
//   four BCD digits by an iterative shift-add-3 (double-dabble) engine, one bit
//   per clock. All four digit codes are updated together when the conversion
//   completes, so the display never shows a partial result.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous, active-high reset
//   wr_en     one-cycle write strobe (ignored while busy)
//   wr_data   unsigned 32-bit value to display
//   blank     blank all digits (only while idle; wr_en wins)
//   busy      conversion in progress
//   done      one-cycle pulse when the digits update after a write
//   overflow  displayed digits represent an out-of-range value
//   dig0..3   digit codes, units..thousands (OVF_CODE = error, BLANK_CODE = blank)
module display_bcd_controller #(
  parameter int CONV_BITS  = 14,
  parameter int MAX_VALUE  = 9999,
  parameter int OVF_CODE   = 14,
  parameter int BLANK_CODE = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        blank,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3
);

  localparam int              CNT_W     = $clog2(CONV_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CONV_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]     MAX_WORD  = 32'(MAX_VALUE);
  localparam logic [3:0]      OVF_DIG   = 4'(OVF_CODE);
  localparam logic [3:0]      BLANK_DIG = 4'(BLANK_CODE);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  state_t               state, state_nx;
  logic [CONV_BITS-1:0] bin_q, bin_nx;
  logic [15:0]          bcd_q, bcd_nx, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic                 ovf_pend_q, ovf_pend_nx;
  logic                 busy_nx, done_nx, overflow_nx;
  logic [3:0]           dig0_nx, dig1_nx, dig2_nx, dig3_nx;

  // Add-3 correction: any BCD nibble >= 5 would become >= 10 after the shift,
  // so it is pre-biased to carry into the next nibble instead.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    bin_nx      = bin_q;
    bcd_nx      = bcd_q;
    cnt_nx      = cnt_q;
    ovf_pend_nx = ovf_pend_q;
    busy_nx     = busy;
    done_nx     = 1'b0;
    overflow_nx = overflow;
    dig0_nx     = dig0;
    dig1_nx     = dig1;
    dig2_nx     = dig2;
    dig3_nx     = dig3;

    unique case (state)
      IDLE: begin
        if (wr_en) begin
          busy_nx = 1'b1;
          if (wr_data > MAX_WORD) begin
            // Out-of-range values skip conversion and go straight to LOAD.
            ovf_pend_nx = 1'b1;
            state_nx    = LOAD;
          end else begin
            ovf_pend_nx = 1'b0;
            bin_nx      = wr_data[CONV_BITS-1:0];
            bcd_nx      = '0;
            cnt_nx      = CNT_INIT;
            state_nx    = CONVERT;
          end
        end else if (blank) begin
          dig0_nx     = BLANK_DIG;
          dig1_nx     = BLANK_DIG;
          dig2_nx     = BLANK_DIG;
          dig3_nx     = BLANK_DIG;
          overflow_nx = 1'b0;
        end
      end

      CONVERT: begin
        bcd_nx = {bcd_adj[14:0], bin_q[CONV_BITS-1]};
        bin_nx = bin_q << 1;
        cnt_nx = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_nx = LOAD;
        end
      end

      LOAD: begin
        if (ovf_pend_q) begin
          dig0_nx     = OVF_DIG;
          dig1_nx     = OVF_DIG;
          dig2_nx     = OVF_DIG;
          dig3_nx     = OVF_DIG;
          overflow_nx = 1'b1;
        end else begin
          dig0_nx     = bcd_q[3:0];
          dig1_nx     = bcd_q[7:4];
          dig2_nx     = bcd_q[11:8];
          dig3_nx     = bcd_q[15:12];
          overflow_nx = 1'b0;
        end
        ovf_pend_nx = 1'b0;
        done_nx     = 1'b1;
        busy_nx     = 1'b0;
        state_nx    = IDLE;
      end

      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      dig0       <= BLANK_DIG;
      dig1       <= BLANK_DIG;
      dig2       <= BLANK_DIG;
      dig3       <= BLANK_DIG;
    end else begin
      state      <= state_nx;
      bin_q      <= bin_nx;
      bcd_q      <= bcd_nx;
      cnt_q      <= cnt_nx;
      ovf_pend_q <= ovf_pend_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      overflow   <= overflow_nx;
      dig0       <= dig0_nx;
      dig1       <= dig1_nx;
      dig2       <= dig2_nx;
      dig3       <= dig3_nx;
    end
  end

endmodule

// File: tb/tb_display_bcd_controller.sv
// Bench for display_bcd_controller: directed scenarios followed by random
// writes/blanks. The stimulus side predicts each accepted event and queues the
// expected display contents with the cycle they should appear; a monitor
// compares every cycle (update cycles, hold cycles and reset cycles).
module tb_display_bcd_controller;

  localparam int LAT_CONV = 15;  // CONV_BITS + 1
  localparam int LAT_OVF  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        blank;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  dig0, dig1, dig2, dig3;

  display_bcd_controller #(
    .CONV_BITS (14),
    .MAX_VALUE (9999),
    .OVF_CODE  (14),
    .BLANK_CODE(15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .blank   (blank),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .dig0    (dig0),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned acc;    // cycle at which the event was accepted
    int unsigned due;    // cycle at which the display must show val
    bit          is_wr;  // write (done expected) or blank (no done)
    logic [16:0] val;    // {overflow, dig3, dig2, dig1, dig0}
  } exp_t;

  exp_t        q[$];
  int unsigned due_last = 0;
  logic [16:0] disp = 17'h0FFFF;
  int          errors = 0;
  int          checks = 0;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [16:0] model(input logic [31:0] v);
    if (v > 32'd9999) return {1'b1, 16'hEEEE};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got {done,busy,ovf,dig}=%b_%b_%b_%h expected %b_%b_%b_%h",
               name, cyc, got[18], got[17], got[16], got[15:0],
               exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [18:0] got;
    logic        bexp;
    forever begin
      @(negedge clk);
      got = {done, busy, overflow, dig3, dig2, dig1, dig0};
      if (rst) begin
        q.delete();
        disp = 17'h0FFFF;
        check("reset", got, {2'b00, disp});
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e    = q.pop_front();
        disp = e.val;
        check(e.is_wr ? "load" : "blank", got, {e.is_wr, 1'b0, e.val});
      end else begin
        bexp = (q.size() > 0) && q[0].is_wr && (cyc >= q[0].acc);
        check("hold", got, {1'b0, bexp, disp});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    while (cyc < due_last) step(1);
  endtask

  task automatic write_val(input logic [31:0] v, input logic b);
    exp_t e;
    wr_en   = 1'b1;
    wr_data = v;
    blank   = b;
    if (cyc >= due_last) begin
      e.acc   = cyc + 1;
      e.val   = model(v);
      e.due   = e.acc + (e.val[16] ? LAT_OVF : LAT_CONV);
      e.is_wr = 1'b1;
      q.push_back(e);
      due_last = e.due;
    end
    step(1);
    wr_en = 1'b0;
    blank = 1'b0;
  endtask

  task automatic do_blank();
    exp_t e;
    wait_idle();
    blank   = 1'b1;
    e.acc   = cyc + 1;
    e.due   = cyc + 1;
    e.is_wr = 1'b0;
    e.val   = 17'h0FFFF;
    q.push_back(e);
    step(1);
    blank = 1'b0;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] v;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    blank   = 1'b0;
    step(3);
    rst = 1'b0;
    due_last = cyc;
    step(1);

    write_val(32'd1234, 1'b0);
    wait_idle(); step(1);

    write_val(32'd9999, 1'b0);
    wait_idle();
    write_val(32'd0, 1'b0);
    wait_idle(); step(1);

    write_val(32'd10000, 1'b0);
    wait_idle(); step(1);
    write_val(32'hFFFF_FFFF, 1'b0);
    wait_idle(); step(1);
    write_val(32'd42, 1'b0);
    wait_idle(); step(1);

    // Write ignored while busy, then one accepted in the done cycle.
    write_val(32'd5678, 1'b0);
    step(4);
    write_val(32'd1111, 1'b0);
    wait_idle();
    write_val(32'd1111, 1'b0);
    wait_idle(); step(1);

    // Reset mid-conversion.
    write_val(32'd305, 1'b0);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    due_last = cyc;
    step(1);
    write_val(32'd7, 1'b0);
    wait_idle(); step(1);

    write_val(32'd2024, 1'b0);
    wait_idle(); step(1);
    do_blank();
    step(1);
    write_val(32'd88, 1'b1);
    wait_idle(); step(1);

    // Random traffic: some writes land while busy and must be ignored.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 18));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_blank();
      end else begin
        v = (r < 3) ? $urandom() : 32'($urandom_range(0, 10050));
        write_val(v, (cyc >= due_last) && ($urandom_range(0, 3) == 0));
      end
    end

    wait_idle();
    step(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_bcd_controller.md
Name: display_bcd_controller

Overview:
- Sequential front end for the 4-digit seven-segment output path.
- Accepts a 32-bit value written by the processor's output instruction and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine instead of combinational divide/modulo.
- Holds the last valid digits stable during a conversion, then updates all four at once.
- Its digit outputs drive the existing 4-bit-code-to-segment decoders directly; code 14 means error "E" and code 15 means blank.

Parameters:
- CONV_BITS, 14, binary bits converted; 9999 needs 14 bits.
- MAX_VALUE, 9999, largest displayable value; must be below both 2^CONV_BITS and 10^4.
- OVF_CODE, 14, digit code driven on all four digits when the value exceeds MAX_VALUE.
- BLANK_CODE, 15, digit code for a blank digit; used at reset and on blank.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  one-cycle write strobe from the output instruction.
- wr_data  input  32  unsigned value to display, sampled when wr_en is accepted.
- blank  input  1  request to blank all digits.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the digit outputs update after a write.
- overflow  output  1  high while the displayed digits represent an out-of-range value.
- dig0  output  4  units digit code.
- dig1  output  4  tens digit code.
- dig2  output  4  hundreds digit code.
- dig3  output  4  thousands digit code.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; dig0..dig3=BLANK_CODE; busy=0; done=0; overflow=0; shift counter=0.
  - Reset during CONVERT aborts the conversion; no done pulse is produced.
- All outputs are registered.
- FSM states are IDLE, CONVERT and LOAD.
- IDLE:
  - wr_en=1 at edge E0 with wr_data>MAX_VALUE: go to LOAD with the overflow flag set; busy=1 from E0.
  - wr_en=1 at edge E0 with wr_data<=MAX_VALUE: capture wr_data[CONV_BITS-1:0] into the binary shift register and clear the 16-bit BCD register; counter=CONV_BITS; go to CONVERT; busy=1 from E0.
  - blank=1 with wr_en=0: at the next edge dig0..dig3=BLANK_CODE and overflow=0; done stays 0; state remains IDLE.
  - wr_en and blank both high: wr_en has priority and blank is ignored.
- CONVERT, one iteration per clock:
  - Add 3 to every BCD nibble that is >=5.
  - Then shift {bcd, bin} left by one bit and decrement the counter.
  - After the iteration that brings the counter to 0 (the CONV_BITS-th cycle), go to LOAD.
- LOAD (single cycle), at its edge:
  - Normal path: dig0..dig3 take the BCD nibbles [3:0], [7:4], [11:8] and [15:12]; overflow=0.
  - Overflow path: dig0..dig3=OVF_CODE; overflow=1.
  - In both cases done=1 and busy=0; return to IDLE.
- done is high for exactly one cycle and deasserts at the following edge.
- Latency, in-range value: wr_en sampled at E0 -> digits and done update at E(CONV_BITS+1), i.e. E15 by default. busy is high during E0..E15 and low from E15.
- Latency, out-of-range value: wr_en at E0 -> digits, overflow and done update at E1.
- wr_en while busy=1 is ignored: no capture and no queuing; the current conversion completes unaffected.
- A new wr_en is accepted in the same cycle that done is high, because the FSM is back in IDLE.
- dig0..dig3 hold their previous values throughout CONVERT, so the display never shows partial results.
- wr_data upper bits need no special handling: the range check covers all 32 bits, so no truncation occurs for accepted values.

Test Plan:
- Reset, then wr_en with wr_data=1234 -> at E15 dig3..dig0=1,2,3,4, done pulses once, overflow=0; busy high for exactly 15 cycles.
- wr_data=9999 -> 9,9,9,9 at E15; then wr_data=0 -> 0,0,0,0; digits hold 9,9,9,9 throughout the second conversion.
- wr_data=10000, and separately 32'hFFFFFFFF -> at E1 all digits=14, overflow=1, done pulse; next write of 42 -> 0,0,4,2 and overflow=0.
- Write 5678, pulse wr_en with 1111 at E5 -> 1111 is ignored and the result is 5,6,7,8; a write of 1111 in the done cycle is accepted -> 1,1,1,1 fifteen cycles later.
- Write 305, assert rst at E7 -> digits=15 immediately, busy=0, no done pulse; after release, a write of 7 -> 0,0,0,7.
- With 2024 displayed and IDLE: blank=1 -> all digits=15; blank and wr_en(88) in the same cycle -> conversion proceeds and yields 0,0,8,8.
